// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch unit, decoder and benches: instruction width,
// R-type opcode/funct encodings and instruction field positions.
package isa_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_ADD    = 6'b100000;
  localparam logic [5:0] FUNCT_SUB    = 6'b100010;
  localparam logic [5:0] FUNCT_SLT    = 6'b101010;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_W      = 16;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] word);
    return word[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {instruction, pc} entries; flush empties it in one cycle.
// Pointers wrap by natural overflow, so DEPTH must be a power of two.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && (count_q != '0) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; entries are only observable through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (count_q < (PtrW+1)'(DEPTH)));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequences the PC, issues 1-cycle-latency memory reads under a
// credit limit, buffers returns in a prefetch FIFO and hands them out over valid/ready.
module inst_fetch
  import isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic [CntW-1:0]   count;
  logic [EntW-1:0]   head;
  logic              req, push, pop, valid, has_credit;

  always_comb begin
    // Buffered plus in-flight words must leave room, so a return never meets a full FIFO.
    has_credit = (32'(count) + 32'(inflight_q)) < DEPTH;
    valid      = count != '0;
    req        = rst_n && enable && !redirect_valid && has_credit;
    push       = inflight_q && !squash_q;
    pop        = valid && inst_ready;

    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = req;
    squash_d   = redirect_valid && inflight_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req) begin
      pc_d       = pc_q + 1'b1;
      req_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({imem_rdata, req_addr_q}),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

  always_comb begin
    imem_req   = req;
    imem_addr  = req ? pc_q : '0;
    inst_valid = valid;
    inst       = valid ? head[EntW-1 -: INST_W] : '0;
    inst_pc    = valid ? head[ADDR_W-1:0] : '0;
    busy       = inflight_q || valid;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, compared every cycle against
// a queue-based model; a second instance with RESET_PC=FE covers PC wrap.
module tb_inst_fetch;
  import isa_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_req, inst_valid, busy;
  logic [7:0]  imem_addr, inst_pc;
  logic [31:0] imem_rdata, inst;

  logic        w_enable = 1'b0;
  logic        w_imem_req, w_inst_valid, w_busy;
  logic [7:0]  w_imem_addr, w_inst_pc;
  logic [31:0] w_imem_rdata, w_inst;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .busy(busy)
  );

  inst_fetch #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(w_enable), .redirect_valid(1'b0),
    .redirect_pc(8'h00), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst(w_inst), .inst_pc(w_inst_pc), .busy(w_busy)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {6'b000000, a[4:0], 21'd0};
  endfunction

  // Memory: data valid one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata   <= imem_req ? mem_word(imem_addr) : $urandom;
    w_imem_rdata <= w_imem_req ? mem_word(w_imem_addr) : $urandom;
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] m_pc;
  bit         m_infl;
  logic [7:0] m_infl_pc;

  bit         s_req, s_valid;
  logic [7:0] s_addr, s_pc;
  logic [31:0] s_inst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 8'h00;
    m_infl = 1'b0;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit en, input bit rv, input logic [7:0] rpc, input bit rdy);
    bit exp_req, pop_m;
    enable         = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_pc    = inst_pc;
    s_inst  = inst;
    exp_req = en && !rv && (q.size() + int'(m_infl)) < DEPTH;
    if (rst_n) begin
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", inst_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("inst_pc", inst_pc, q[0]);
        chk("inst", inst, mem_word(q[0]));
      end
      chk("busy", busy, m_infl || q.size() > 0);
    end else begin
      chk("imem_req_in_reset", imem_req, 0);
      chk("inst_valid_in_reset", inst_valid, 0);
    end
    @(posedge clk);
    if (rst_n) begin
      pop_m = q.size() > 0 && rdy;
      if (pop_m) void'(q.pop_front());
      if (rv) begin
        q.delete();
        m_pc   = rpc;
        m_infl = 1'b0;
      end else begin
        if (m_infl) q.push_back(m_infl_pc);
        m_infl = exp_req;
        if (exp_req) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 8'd1;
        end
      end
    end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int nreq;
    logic [7:0] e;
    model_reset();

    // Reset state, with enable already high.
    enable     = 1'b1;
    inst_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming: addresses 0,1,2..., first valid two cycles after first request.
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 8'h00, 1);
      chk("t1_req", s_req, 1);
      chk("t1_addr", s_addr, k);
      if (k == 1) chk("t1_valid_early", s_valid, 0);
      if (k >= 2) begin
        chk("t1_valid", s_valid, 1);
        chk("t1_pc", s_pc, k - 2);
      end
    end

    // Stall: exactly DEPTH requests, head held, refill after first pop.
    step(1, 1, 8'h00, 0);
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h00, 0);
      nreq += int'(s_req);
    end
    chk("t2_req_count", nreq, DEPTH);
    chk("t2_hold_valid", s_valid, 1);
    chk("t2_hold_pc", s_pc, 8'h00);
    chk("t2_hold_inst", s_inst, 32'h0);
    step(1, 0, 8'h00, 1);
    chk("t2_no_req_at_pop", s_req, 0);
    step(1, 0, 8'h00, 1);
    chk("t2_refill_req", s_req, 1);
    chk("t2_refill_addr", s_addr, 8'h04);
    for (int k = 0; k < 4; k++) step(1, 0, 8'h00, 1);

    // Redirect while word 5 is in flight and two words are buffered.
    step(1, 1, 8'h03, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 8'h00, 0);
    step(1, 1, 8'h40, 0);
    step(1, 0, 8'h00, 1);
    chk("t3_valid_after", s_valid, 0);
    chk("t3_req", s_req, 1);
    chk("t3_addr", s_addr, 8'h40);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    chk("t3_first_valid", s_valid, 1);
    chk("t3_first_pc", s_pc, 8'h40);

    // Redirect coinciding with a pop handshake.
    step(1, 0, 8'h00, 1);
    step(1, 1, 8'h80, 1);
    chk("t4_pop_in_redirect", s_valid, 1);
    chk("t4_pop_pc", s_pc, 8'h42);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    chk("t4_first_valid", s_valid, 1);
    chk("t4_first_pc", s_pc, 8'h80);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           8'($urandom), ($urandom_range(0, 4) < 3));
    end

    // Asynchronous reset with three words buffered and one in flight.
    step(1, 1, 8'h10, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 8'h00, 0);
    chk("t6_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6");
    model_reset();
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    rst_n = 1'b1;
    step(1, 0, 8'h00, 1);
    chk("t6_first_req", s_req, 1);
    chk("t6_first_addr", s_addr, 8'h00);
    for (int k = 0; k < 8; k++) step(1, 0, 8'h00, 1);

    // PC wrap on the RESET_PC=FE instance.
    w_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        e = 8'hFE + 8'(k);
        chk("t5_req", w_imem_req, 1);
        chk("t5_addr", w_imem_addr, e);
      end
      if (k >= 2) begin
        e = 8'hFE + 8'(k - 2);
        chk("t5_valid", w_inst_valid, 1);
        chk("t5_pc", w_inst_pc, e);
        chk("t5_inst", w_inst, mem_word(e));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch and issue unit; the producer side of the 32-bit instruction word consumed by the ALU/decoder.
- Sequences a word-addressed program counter and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small prefetch FIFO and presents them to the decoder over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all buffered and in-flight words.

Parameters:
- ADDR_W, 8, width of the word address / PC; PC wraps modulo 2^ADDR_W.
- DEPTH, 4, prefetch FIFO entries; must be a power of two, at least 2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- enable  input  1  fetch permitted; when 0, no new memory requests are issued, and draining continues.
- redirect_valid  input  1  one-cycle pulse that loads a new PC and flushes.
- redirect_pc  input  ADDR_W  target word address for the redirect.
- imem_req  output  1  memory read strobe.
- imem_addr  output  ADDR_W  memory word address; valid when imem_req=1.
- imem_rdata  input  32  read data; valid exactly one cycle after an accepted imem_req.
- inst_valid  output  1  FIFO head holds an instruction.
- inst_ready  input  1  decoder accepts the head this cycle.
- inst  output  32  instruction word at the FIFO head.
- inst_pc  output  ADDR_W  word address of inst.
- busy  output  1  a read is in flight or the FIFO is non-empty.

Behaviour:
Reset values
- pc=RESET_PC; FIFO empty with count=0.
- inflight=0, squash=0.
- All outputs 0: imem_req, imem_addr, inst_valid, inst, inst_pc, busy.

Request issue
- imem_req=1 when enable && !redirect_valid && (count + inflight) < DEPTH.
- imem_addr=pc.
- On a request, pc <= pc+1 (wraps), inflight <= 1, and the issued address is saved for inst_pc.
- Sustained throughput is 1 word per cycle while space remains.
- The requirement is combinational; memory always accepts.

Return
- The cycle after a request, imem_rdata and the saved address are pushed, unless squash=1, in which case they are discarded.
- Push and pop may occur in the same cycle; count is unchanged.
- The credit check guarantees a push never finds the FIFO full. Assert count<DEPTH on push in simulation.

Handshake
- Transfer occurs when inst_valid && inst_ready.
- inst and inst_pc hold stable while inst_valid=1 && !inst_ready.
- inst_valid=(count>0), registered FIFO state.
- Minimum latency from request to inst_valid is 2 edges: the request edge captures the address, and the return edge writes the FIFO.

Redirect
- In the redirect cycle: pc <= redirect_pc, count <= 0, and no request is issued.
- squash <= inflight, so a word returning next cycle is dropped.
- A pop handshaking in the redirect cycle completes normally; the decoder keeps that word.
- inst_valid is 0 the cycle after redirect.
- The first request to redirect_pc occurs the cycle after redirect (if enabled).
- Back-to-back redirects: the last one wins.

Enable low
- Stops new requests only. The in-flight word still lands, and the FIFO drains normally.

busy
- busy=inflight || count>0.

Reset mid-operation
- All state returns to reset values immediately, and in-flight data is dropped.
- The memory response arriving after reset release is ignored, because inflight=0.

Decomposition:
- Shared package (isa_pkg): INST_W=32, OPCODE_RTYPE=6'b000000, FUNCT_ADD=6'b100000, FUNCT_SUB=6'b100010, FUNCT_SLT=6'b101010.
- The package also holds field-position constants for rs/rt/rd/funct/imm, shared with the decoder and benches.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with data width 32+ADDR_W.
  - Ports: push, pop, flush, count, head.
  - Pointer wrap by natural overflow.
- The PC, credit and squash logic stay in inst_fetch.

Test Plan:
1. Reset then enable=1, inst_ready=1, memory word n = {6'b000000, n[4:0], 21'd0}:
   - imem_addr sequence is 0,1,2,3…, one per cycle.
   - First inst_valid 2 cycles after first request.
   - inst_pc 0,1,2… back-to-back with no bubbles.
2. inst_ready=0 with enable=1:
   - Exactly DEPTH=4 requests are issued (addresses 0–3), then imem_req=0.
   - inst holds word 0 stable.
   - Raising inst_ready drains in order 0–3; the request at 4 is re-issued in the cycle after the first pop.
3. Redirect to 8'h40 in the cycle after the request at address 5, with 2 words buffered:
   - Word 5 is squashed and the FIFO is flushed.
   - inst_valid=0 next cycle.
   - Next imem_addr=8'h40, and the first delivered inst_pc is 8'h40.
4. Simultaneous redirect and pop handshake:
   - The popped word is counted as delivered.
   - No word older than the redirect appears afterwards.
5. PC wrap with RESET_PC=8'hFE:
   - imem_addr sequence is FE, FF, 00, 01.
   - inst_pc follows the same sequence.
6. Assert rst_n low asynchronously mid-stream with count=3 and a read in flight:
   - Outputs are 0 before the next clk edge.
   - After release, the first request is to RESET_PC.
   - The stale rdata is never presented.
